// File: rtl/fpga_gpio_pkg.sv
// fpga_gpio_pkg: shared defaults and types for the GPIO conditioning block.
//   NUM_GPIO_DEF / SYNC_STAGES_DEF / DEB_W_DEF : parameter defaults
//   DEB_DEFAULT : debounce limit for board use (about 20 us at 50 MHz)
//   irq_ctl_t   : per-channel interrupt controls handed to each channel
package fpga_gpio_pkg;
  localparam int NUM_GPIO_DEF    = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_W_DEF       = 16;
  localparam int DEB_DEFAULT     = 1000;

  typedef struct packed {
    logic rise_en;
    logic fall_en;
    logic clr;
  } irq_ctl_t;
endpackage

// File: rtl/fpga_gpio_cond_ch.sv
// gpio_debounce_ch: one GPIO input channel.
//   clk, rst_n    : clock, synchronous active-low reset
//   pad_i         : asynchronous pin
//   deb_limit_i   : debounce limit (quasi-static)
//   ctl_i         : rise/fall enables and pending clear
//   lvl_o         : debounced stable level
//   pend_o        : sticky edge-pending flag
module gpio_debounce_ch
  import fpga_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad_i,
  input  logic [DEB_W-1:0] deb_limit_i,
  input  irq_ctl_t         ctl_i,
  output logic             lvl_o,
  output logic             pend_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   stb_q, stb_d;
  logic                   stb_dly_q;
  logic                   pend_q, pend_d;
  logic                   sync, rise, fall;

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = stb_q & ~stb_dly_q;
  assign fall = ~stb_q & stb_dly_q;

  // Counter only runs while the synced input disagrees with the stable level;
  // the >= compare means a lowered limit mid-count takes effect immediately
  // instead of letting the counter run on toward a wrap.
  always_comb begin
    cnt_d = '0;
    stb_d = stb_q;
    if (sync != stb_q) begin
      if (cnt_q >= deb_limit_i) stb_d = sync;
      else                      cnt_d = cnt_q + DEB_W'(1);
    end
    // set wins over a simultaneous clear
    pend_d = (pend_q & ~ctl_i.clr) | (rise & ctl_i.rise_en) | (fall & ctl_i.fall_en);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
      stb_dly_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_i};
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      stb_dly_q <= stb_q;
      pend_q    <= pend_d;
    end
  end

  assign lvl_o  = stb_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/fpga_gpio_cond.sv
// fpga_gpio_cond: GPIO pin conditioning between board pads and SoC.
//   clk, rst_n          : clock, synchronous active-low reset
//   pad_in              : asynchronous pins -> synchronised, debounced -> gpio_in
//   deb_limit           : debounce limit; level accepted after deb_limit+1 cycles
//   gpio_out, gpio_dir  : SoC drive data / direction -> registered pad_out / pad_oe
//   rise_en, fall_en    : per-channel edge interrupt enables
//   irq_clr             : per-channel pending-clear pulses
//   irq_pend, irq_o     : sticky pending flags and their OR
module fpga_gpio_cond
  import fpga_gpio_pkg::*;
#(
  parameter int NUM_GPIO    = NUM_GPIO_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_GPIO-1:0] pad_in,
  input  logic [DEB_W-1:0]    deb_limit,
  output logic [NUM_GPIO-1:0] gpio_in,
  input  logic [NUM_GPIO-1:0] gpio_out,
  input  logic [NUM_GPIO-1:0] gpio_dir,
  output logic [NUM_GPIO-1:0] pad_out,
  output logic [NUM_GPIO-1:0] pad_oe,
  input  logic [NUM_GPIO-1:0] rise_en,
  input  logic [NUM_GPIO-1:0] fall_en,
  input  logic [NUM_GPIO-1:0] irq_clr,
  output logic [NUM_GPIO-1:0] irq_pend,
  output logic                irq_o
);
  logic [NUM_GPIO-1:0] pad_out_q, pad_oe_q;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_ch
    irq_ctl_t ctl;
    assign ctl = '{rise_en: rise_en[g], fall_en: fall_en[g], clr: irq_clr[g]};
    gpio_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pad_i      (pad_in[g]),
      .deb_limit_i(deb_limit),
      .ctl_i      (ctl),
      .lvl_o      (gpio_in[g]),
      .pend_o     (irq_pend[g])
    );
  end

  // Output path: plain register stage, independent of the input path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      pad_out_q <= gpio_out;
      pad_oe_q  <= gpio_dir;
    end
  end

  assign pad_out = pad_out_q;
  assign pad_oe  = pad_oe_q;
  assign irq_o   = |irq_pend;
endmodule

// File: tb/tb_fpga_gpio_cond.sv
module tb_fpga_gpio_cond;
  localparam int N = 32;
  localparam int S = 2;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pad_in, gpio_in, gpio_out, gpio_dir, pad_out, pad_oe;
  logic [N-1:0] rise_en, fall_en, irq_clr, irq_pend;
  logic [W-1:0] deb_limit;
  logic         irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpga_gpio_cond #(.NUM_GPIO(N), .SYNC_STAGES(S), .DEB_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .pad_in(pad_in), .deb_limit(deb_limit),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .pad_out(pad_out), .pad_oe(pad_oe), .rise_en(rise_en), .fall_en(fall_en),
    .irq_clr(irq_clr), .irq_pend(irq_pend), .irq_o(irq_o)
  );

  typedef struct packed {
    logic [N-1:0] dir;
    logic [N-1:0] dout;
  } ovec_t;

  typedef struct packed {
    logic [N-1:0] oe;
    logic [N-1:0] dout;
  } oexp_t;

  ovec_t vecs[5];
  oexp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    oexp_t e, prev;
    logic seen;

    vecs[0] = '{dir: 32'hFFFF0000, dout: 32'hA5A5A5A5};
    vecs[1] = '{dir: 32'h00000000, dout: 32'hFFFFFFFF};
    vecs[2] = '{dir: 32'hFFFFFFFF, dout: 32'h00000000};
    vecs[3] = '{dir: 32'h0F0F0F0F, dout: 32'h5A5A5A5A};
    vecs[4] = '{dir: 32'h12345678, dout: 32'h87654321};

    // reset with every input driven non-zero where possible
    rst_n = 1'b0; pad_in = '0; deb_limit = W'(3);
    gpio_out = '1; gpio_dir = '1;
    rise_en = 32'h1; fall_en = 32'h80; irq_clr = '0;
    step(); step(); step();
    chk("rst_gpio_in", gpio_in, '0);
    chk("rst_pad_out", pad_out, '0);
    chk("rst_pad_oe", pad_oe, '0);
    chk("rst_irq_pend", irq_pend, '0);
    chk("rst_irq_o", {31'b0, irq_o}, '0);

    gpio_out = '0; gpio_dir = '0;
    rst_n = 1'b1;
    step();
    chk("rel_no_edge", irq_pend, '0);

    // output path: table with scoreboard, one-cycle latency
    prev = '{oe: '0, dout: '0};
    foreach (vecs[i]) begin
      gpio_dir = vecs[i].dir; gpio_out = vecs[i].dout;
      sb.push_back('{oe: vecs[i].dir, dout: vecs[i].dout});
      #1;
      chk("out_latency_oe", pad_oe, prev.oe);
      chk("out_latency_out", pad_out, prev.dout);
      step();
      e = sb.pop_front();
      chk("out_oe", pad_oe, e.oe);
      chk("out_out", pad_out, e.dout);
      prev = e;
    end

    // rise on ch0, deb_limit=3: stable after S+4 edges, pend one edge later
    pad_in[0] = 1'b1;
    for (int k = 1; k <= S + 5; k++) begin
      step();
      chk($sformatf("deb0_lvl_k%0d", k), {31'b0, gpio_in[0]}, {31'b0, k >= S + 4});
      chk($sformatf("deb0_pend_k%0d", k), {31'b0, irq_pend[0]}, {31'b0, k >= S + 5});
    end
    chk("deb0_irq_o", {31'b0, irq_o}, 32'h1);

    // 3-cycle glitch on ch5 is rejected
    pad_in[5] = 1'b1;
    step(); step(); step();
    pad_in[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch5_lvl", {31'b0, gpio_in[5]}, '0);
      chk("glitch5_pend", {31'b0, irq_pend[5]}, '0);
    end

    // 4-cycle pulse on ch6 is just long enough to be accepted
    seen = 1'b0;
    pad_in[6] = 1'b1;
    step(); step(); step(); step();
    pad_in[6] = 1'b0;
    seen |= gpio_in[6];
    for (int k = 0; k < 10; k++) begin
      step();
      seen |= gpio_in[6];
    end
    chk("pulse6_seen", {31'b0, seen}, 32'h1);
    chk("pulse6_final", {31'b0, gpio_in[6]}, '0);

    // clear everything pending
    irq_clr = '1;
    step();
    irq_clr = '0;
    chk("clr_all_pend", irq_pend, '0);
    chk("clr_all_irq_o", {31'b0, irq_o}, '0);

    // ch7 fall: clear pulsed the same cycle the fall sets pending -> set wins
    deb_limit = W'(0);
    pad_in[7] = 1'b1;
    for (int k = 0; k < S + 2; k++) step();
    chk("fall7_hi", {31'b0, gpio_in[7]}, 32'h1);
    chk("fall7_no_rise_pend", {31'b0, irq_pend[7]}, '0);
    pad_in[7] = 1'b0;
    for (int k = 0; k < S + 1; k++) step();
    chk("fall7_lvl", {31'b0, gpio_in[7]}, '0);
    chk("fall7_pre_pend", {31'b0, irq_pend[7]}, '0);
    irq_clr[7] = 1'b1;
    step();
    irq_clr[7] = 1'b0;
    chk("fall7_setwins", {31'b0, irq_pend[7]}, 32'h1);
    chk("fall7_irq_o", {31'b0, irq_o}, 32'h1);
    step();
    chk("fall7_sticky", {31'b0, irq_pend[7]}, 32'h1);
    irq_clr[7] = 1'b1;
    step();
    irq_clr[7] = 1'b0;
    chk("fall7_cleared", {31'b0, irq_pend[7]}, '0);
    chk("fall7_irq_o_off", {31'b0, irq_o}, '0);

    // ch9: limit lowered 10 -> 2 while cnt = 6
    deb_limit = W'(10);
    pad_in[9] = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("lim9_counting", {31'b0, gpio_in[9]}, '0);
    deb_limit = W'(2);
    step();
    chk("lim9_accept", {31'b0, gpio_in[9]}, 32'h1);

    // reset mid-count with all pads high, then full re-debounce
    deb_limit = W'(3);
    pad_in = '1;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("rst2_gpio_in", gpio_in, '0);
    chk("rst2_pend", irq_pend, '0);
    chk("rst2_irq_o", {31'b0, irq_o}, '0);
    chk("rst2_pad_oe", pad_oe, '0);
    chk("rst2_pad_out", pad_out, '0);
    rst_n = 1'b1;
    for (int k = 1; k <= S + 5; k++) begin
      step();
      if (k == 1) chk("rst2_pad_out_rel", pad_out, 32'h87654321);
      chk($sformatf("rst2_lvl_k%0d", k), gpio_in, (k >= S + 4) ? '1 : '0);
      chk($sformatf("rst2_pend_k%0d", k), irq_pend, (k >= S + 5) ? 32'h1 : '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
